framebuffer_scaler: RTL and testbench

//  Parametrised single-clock frame store between the Mandelbrot pixel producer (write side)
//  and the VGA timing/output stage (read side). Writes one raster frame of IMG_W x IMG_H pixels.

---
 rtl/framebuffer_scaler_if.sv | 27 ++
 rtl/framebuffer_scaler.sv | 201 ++++++++++++++++++++
 tb/tb_framebuffer_scaler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_scaler_if.sv
// Handshake bundle between the pixel producer / VGA stage and framebuffer_scaler.
// master = producer+display side, slave = frame store.
interface framebuffer_scaler_if #(
    parameter int PIX_W = 4
) ();
    logic [PIX_W-1:0] wr_data;
    logic             wr_en;
    logic             wr_sof;
    logic             wr_frame_done;
    logic             wr_overflow;
    logic             rd_en;
    logic             rd_sof;
    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;
    logic             rd_frame_done;
    logic             rd_bank;

    modport master (
        output wr_data, wr_en, wr_sof, rd_en, rd_sof,
        input  wr_frame_done, wr_overflow, rd_data, rd_valid, rd_frame_done, rd_bank
    );

    modport slave (
        input  wr_data, wr_en, wr_sof, rd_en, rd_sof,
        output wr_frame_done, wr_overflow, rd_data, rd_valid, rd_frame_done, rd_bank
    );
endinterface

// File: rtl/framebuffer_scaler.sv
// Single-clock frame store with counter-based integer upscaling on the read side.
// Define FRAMEBUFFER_DOUBLE_BUFFER_EN for a second bank and tear-free bank swapping.
//
// state   | meaning
// WR_FILL | accepting pixels at wr_ptr_q
// WR_FULL | last pixel written; further wr_en is dropped and flagged as overflow
module framebuffer_scaler #(
    parameter int PIX_W   = 4,
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int H_SCALE = 2,
    parameter int V_SCALE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    framebuffer_scaler_if.slave bus
);
    localparam int DEPTH = IMG_W * IMG_H;
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int RAM_DEPTH = DEPTH * NBANK;
    localparam int AW  = $clog2(DEPTH);
    localparam int RAW = $clog2(RAM_DEPTH);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int HW  = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int VW  = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

    typedef enum logic {WR_FILL, WR_FULL} wr_state_e;

    wr_state_e        wr_state_q, wr_state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, wr_addr;
    logic             wr_ovf_q, wr_ovf_d;
    logic             wr_done_q, wr_done_d;
    logic             wr_we;

    logic [HW-1:0]    hsub_q, hsub_d, hsub_c;
    logic [CW-1:0]    col_q, col_d, col_c;
    logic [VW-1:0]    vsub_q, vsub_d, vsub_c;
    logic [RW-1:0]    row_q, row_d, row_c;
    logic [AW-1:0]    base_q, base_d, base_c;
    logic [AW-1:0]    rd_addr;
    logic             rd_wrap;
    logic             rd_valid_q, rd_done_q;
    logic [PIX_W-1:0] rd_data_q;

    logic [PIX_W-1:0] mem [RAM_DEPTH];
    logic [RAW-1:0]   ram_waddr, ram_raddr;
    logic             swap;

    // Write side: wr_sof re-arms the frame before the same-cycle wr_en is evaluated.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_ovf_d   = wr_ovf_q;
        wr_done_d  = 1'b0;
        wr_we      = 1'b0;
        wr_addr    = wr_ptr_q;
        if (bus.wr_sof) begin
            wr_state_d = WR_FILL;
            wr_ptr_d   = '0;
            wr_ovf_d   = 1'b0;
            wr_addr    = '0;
        end
        if (bus.wr_en) begin
            if (bus.wr_sof || wr_state_q == WR_FILL) begin
                wr_we = 1'b1;
                if (wr_addr == AW'(DEPTH - 1)) begin
                    wr_done_d  = 1'b1;
                    wr_ptr_d   = '0;
                    wr_state_d = WR_FULL;
                end else begin
                    wr_ptr_d = wr_addr + 1'b1;
                end
            end else begin
                wr_ovf_d = 1'b1;
            end
        end
        if (swap) begin
            wr_state_d = WR_FILL;
            wr_ptr_d   = '0;
            wr_ovf_d   = 1'b0;
        end
    end

    // Read raster: rd_sof zeroes the position used this cycle, so it outranks any wrap.
    always_comb begin
        hsub_c  = bus.rd_sof ? '0 : hsub_q;
        col_c   = bus.rd_sof ? '0 : col_q;
        vsub_c  = bus.rd_sof ? '0 : vsub_q;
        row_c   = bus.rd_sof ? '0 : row_q;
        base_c  = bus.rd_sof ? '0 : base_q;
        hsub_d  = hsub_c;
        col_d   = col_c;
        vsub_d  = vsub_c;
        row_d   = row_c;
        base_d  = base_c;
        rd_wrap = 1'b0;
        rd_addr = base_c + AW'(col_c);
        if (bus.rd_en) begin
            if (hsub_c == HW'(H_SCALE - 1)) begin
                hsub_d = '0;
                if (col_c == CW'(IMG_W - 1)) begin
                    col_d = '0;
                    if (vsub_c == VW'(V_SCALE - 1)) begin
                        vsub_d = '0;
                        if (row_c == RW'(IMG_H - 1)) begin
                            row_d   = '0;
                            base_d  = '0;
                            rd_wrap = 1'b1;
                        end else begin
                            row_d  = row_c + 1'b1;
                            base_d = base_c + AW'(IMG_W);
                        end
                    end else begin
                        vsub_d = vsub_c + 1'b1;
                    end
                end else begin
                    col_d = col_c + 1'b1;
                end
            end else begin
                hsub_d = hsub_c + 1'b1;
            end
        end
    end

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    logic rd_bank_q, rd_bank_d, swap_pend_q, swap_pend_d, rd_bank_eff;

    assign swap        = swap_pend_q && (rd_wrap || bus.rd_sof);
    assign rd_bank_d   = rd_bank_q ^ swap;
    assign swap_pend_d = (swap_pend_q && !swap) || wr_done_d;
    // A pixel fetched together with rd_sof belongs to the new frame, so it sees the new bank.
    assign rd_bank_eff = bus.rd_sof ? rd_bank_d : rd_bank_q;
    assign ram_waddr   = rd_bank_q ? RAW'(wr_addr) : RAW'(DEPTH) + RAW'(wr_addr);
    assign ram_raddr   = rd_bank_eff ? RAW'(DEPTH) + RAW'(rd_addr) : RAW'(rd_addr);
    assign bus.rd_bank = rd_bank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank_q   <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            rd_bank_q   <= rd_bank_d;
            swap_pend_q <= swap_pend_d;
        end
    end
`else
    assign swap        = 1'b0;
    assign ram_waddr   = RAW'(wr_addr);
    assign ram_raddr   = RAW'(rd_addr);
    assign bus.rd_bank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && wr_we) begin
            mem[ram_waddr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q <= WR_FILL;
            wr_ptr_q   <= '0;
            wr_ovf_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            hsub_q     <= '0;
            col_q      <= '0;
            vsub_q     <= '0;
            row_q      <= '0;
            base_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_ovf_q   <= wr_ovf_d;
            wr_done_q  <= wr_done_d;
            hsub_q     <= hsub_d;
            col_q      <= col_d;
            vsub_q     <= vsub_d;
            row_q      <= row_d;
            base_q     <= base_d;
            rd_valid_q <= bus.rd_en;
            rd_done_q  <= rd_wrap;
            if (bus.rd_en) begin
                rd_data_q <= mem[ram_raddr];
            end
        end
    end

    assign bus.wr_frame_done = wr_done_q;
    assign bus.wr_overflow   = wr_ovf_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_frame_done = rd_done_q;
endmodule

// File: tb/tb_framebuffer_scaler.sv
// Self-checking bench for framebuffer_scaler (4x3 image, 2x2 scaling) against a linear-index
// reference model; double-buffer scenario runs when FRAMEBUFFER_DOUBLE_BUFFER_EN is defined.
module tb_framebuffer_scaler;
    localparam int PW    = 4;
    localparam int W     = 4;
    localparam int H     = 3;
    localparam int HS    = 2;
    localparam int VS    = 2;
    localparam int DEPTH = W * H;
    localparam int TOT   = DEPTH * HS * VS;
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    framebuffer_scaler_if #(.PIX_W(PW)) bus ();

    framebuffer_scaler #(
        .PIX_W(PW), .IMG_W(W), .IMG_H(H), .H_SCALE(HS), .V_SCALE(VS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: memory with validity flags, read position as a linear scaled-pixel index.
    logic [PW-1:0] m_mem   [2*DEPTH];
    bit            m_known [2*DEPTH];
    int            m_ptr, m_pos;
    bit            m_full, m_ovf, m_pend, m_bank;
    bit            m_rvalid, m_rdone, m_wdone, m_rknown;
    logic [PW-1:0] m_rdata;

    function automatic int scaled_addr(input int p);
        int x, y;
        x = p % (W * HS);
        y = p / (W * HS);
        return (y / VS) * W + x / HS;
    endfunction

    function automatic void model_step(input bit wen, input bit wsof, input logic [PW-1:0] wd,
                                       input bit ren, input bit rsof);
        int  pos, idx;
        bit  boundary, swap, rbank;
        if (!rst_n) begin
            m_ptr = 0; m_pos = 0; m_full = 0; m_ovf = 0; m_pend = 0; m_bank = 0;
            m_rvalid = 0; m_rdone = 0; m_wdone = 0; m_rdata = '0; m_rknown = 1;
            return;
        end
        pos      = rsof ? 0 : m_pos;
        boundary = rsof || (ren && pos == TOT - 1);
        swap     = DBL && m_pend && boundary;
        rbank    = (rsof && swap) ? !m_bank : m_bank;
        m_rvalid = ren;
        m_rdone  = ren && (pos == TOT - 1);
        if (ren) begin
            idx      = (rbank ? DEPTH : 0) + scaled_addr(pos);
            m_rdata  = m_mem[idx];
            m_rknown = m_known[idx];
            m_pos    = (pos + 1) % TOT;
        end else begin
            m_pos = pos;
        end
        m_wdone = 0;
        if (wsof) begin
            m_ptr = 0; m_full = 0; m_ovf = 0;
        end
        if (wen) begin
            if (!m_full) begin
                idx = (DBL && !m_bank ? DEPTH : 0) + m_ptr;
                m_mem[idx]   = wd;
                m_known[idx] = 1;
                if (m_ptr == DEPTH - 1) begin
                    m_full = 1; m_wdone = 1; m_ptr = 0;
                end else begin
                    m_ptr++;
                end
            end else begin
                m_ovf = 1;
            end
        end
        m_pend = (m_pend && !swap) || m_wdone;
        if (swap) begin
            m_bank = !m_bank; m_ptr = 0; m_full = 0; m_ovf = 0;
        end
    endfunction

    task automatic tick(input bit wen, input bit wsof, input logic [PW-1:0] wd,
                        input bit ren, input bit rsof);
        bus.wr_en   = wen;
        bus.wr_sof  = wsof;
        bus.wr_data = wd;
        bus.rd_en   = ren;
        bus.rd_sof  = rsof;
        model_step(wen, wsof, wd, ren, rsof);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(0, 0, '0, 0, 0);
        tick(0, 0, '0, 0, 0);
        total += 6;
        if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        if (bus.rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL reset_wr_overflow got=%b exp=0", bus.wr_overflow); end
        if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL reset_rd_bank got=%b exp=0", bus.rd_bank); end
        if (bus.wr_frame_done !== 1'b0) begin bad++; $display("FAIL reset_wr_done got=%b exp=0", bus.wr_frame_done); end
        if (bus.rd_frame_done !== 1'b0) begin bad++; $display("FAIL reset_rd_done got=%b exp=0", bus.rd_frame_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_frame();
        int pulses = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, i == 0, PW'(i), 0, 0);
            if (bus.wr_frame_done === 1'b1) pulses++;
            total++;
            if (bus.wr_frame_done !== m_wdone) begin
                bad++; $display("FAIL wr_done write=%0d got=%b exp=%b", i, bus.wr_frame_done, m_wdone);
            end
        end
        tick(0, 0, '0, 0, 0);
        total += 3;
        if (pulses != 1) begin bad++; $display("FAIL wr_done_count got=%0d exp=1", pulses); end
        if (bus.wr_frame_done !== 1'b0) begin bad++; $display("FAIL wr_done_clear got=%b exp=0", bus.wr_frame_done); end
        if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL wr_ovf_after_frame got=%b exp=0", bus.wr_overflow); end
    endtask

    task automatic read_frame(input string tag);
        int dones = 0;
        for (int i = 0; i < TOT; i++) begin
            tick(0, 0, '0, 1, i == 0);
            total += 2;
            if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL %s_valid i=%0d got=%b exp=1", tag, i, bus.rd_valid); end
            if (bus.rd_frame_done !== (i == TOT - 1)) begin
                bad++; $display("FAIL %s_rd_done i=%0d got=%b exp=%b", tag, i, bus.rd_frame_done, i == TOT - 1);
            end
            if (m_rknown) begin
                total++;
                if (bus.rd_data !== m_rdata) begin
                    bad++; $display("FAIL %s_data i=%0d got=%h exp=%h", tag, i, bus.rd_data, m_rdata);
                end
            end
            if (bus.rd_frame_done === 1'b1) dones++;
        end
        total++;
        if (dones != 1) begin bad++; $display("FAIL %s_rd_done_count got=%0d exp=1", tag, dones); end
    endtask

    task automatic test_read_frame();
        logic [PW-1:0] held;
        read_frame("frame");
        held = bus.rd_data;
        tick(0, 0, '0, 0, 0);
        total += 2;
        if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", bus.rd_valid); end
        if (bus.rd_data !== held) begin bad++; $display("FAIL hold_data got=%h exp=%h", bus.rd_data, held); end
        // position wrapped: a read without rd_sof starts at pixel 0
        tick(0, 0, '0, 1, 0);
        total++;
        if (bus.rd_data !== m_rdata) begin bad++; $display("FAIL wrap_data got=%h exp=%h", bus.rd_data, m_rdata); end
    endtask

    task automatic test_overflow();
        tick(1, 0, PW'(15), 0, 0);
        total++;
        if (bus.wr_overflow !== m_ovf) begin bad++; $display("FAIL overflow_set got=%b exp=%b", bus.wr_overflow, m_ovf); end
        read_frame("reread");
        tick(0, 1, '0, 0, 0);
        total++;
        if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b exp=0", bus.wr_overflow); end
    endtask

    task automatic test_mid_sof();
        for (int i = 0; i < 17; i++) tick(0, 0, '0, 1, i == 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, '0, 1, i == 0);
            if (m_rknown) begin
                total++;
                if (bus.rd_data !== m_rdata) begin
                    bad++; $display("FAIL mid_sof_data k=%0d got=%h exp=%h", i, bus.rd_data, m_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 9; i++) tick(0, 0, '0, 1, 0);
        rst_n = 1'b0;
        tick(0, 0, '0, 1, 0);
        total += 2;
        if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.rd_valid); end
        if (bus.rd_data !== '0) begin bad++; $display("FAIL midrst_data got=%h exp=0", bus.rd_data); end
        rst_n = 1'b1;
        tick(0, 0, '0, 1, 0);
        if (m_rknown) begin
            total++;
            if (bus.rd_data !== m_rdata) begin bad++; $display("FAIL midrst_first got=%h exp=%h", bus.rd_data, m_rdata); end
        end
        read_frame("intact");
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick($urandom_range(1, 0) == 1, $urandom_range(39, 0) == 0, PW'($urandom),
                 $urandom_range(3, 0) != 0, $urandom_range(59, 0) == 0);
            total += 5;
            if (bus.rd_valid !== m_rvalid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.rd_valid, m_rvalid); end
            if (bus.rd_frame_done !== m_rdone) begin bad++; $display("FAIL rnd_rd_done c=%0d got=%b exp=%b", c, bus.rd_frame_done, m_rdone); end
            if (bus.wr_frame_done !== m_wdone) begin bad++; $display("FAIL rnd_wr_done c=%0d got=%b exp=%b", c, bus.wr_frame_done, m_wdone); end
            if (bus.wr_overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, bus.wr_overflow, m_ovf); end
            if (bus.rd_bank !== m_bank) begin bad++; $display("FAIL rnd_bank c=%0d got=%b exp=%b", c, bus.rd_bank, m_bank); end
            if (m_rknown) begin
                total++;
                if (bus.rd_data !== m_rdata) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.rd_data, m_rdata); end
            end
        end
    endtask

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        rst_n = 1'b0;
        tick(0, 0, '0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, i == 0, PW'(i), 0, 0);
            total++;
            if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL db_bank_wrA i=%0d got=%b exp=0", i, bus.rd_bank); end
        end
        // frame A becomes visible at this rd_sof; frame B is written while it is shown
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < TOT; i++) begin
                tick(f == 1 && i < DEPTH, f == 1 && i == 0, PW'(5), 1, f == 0 && i == 0);
                total += 2;
                if (bus.rd_bank !== ((f == 2 || (f == 1 && i == TOT - 1)) ? 1'b0 : 1'b1)) begin
                    bad++; $display("FAIL db_bank f=%0d i=%0d got=%b", f, i, bus.rd_bank);
                end
                if ((f < 2) ? (bus.rd_data === PW'(5)) : (bus.rd_data !== PW'(5))) begin
                    bad++; $display("FAIL db_content f=%0d i=%0d got=%h", f, i, bus.rd_data);
                end
                if (m_rknown) begin
                    total++;
                    if (bus.rd_data !== m_rdata) begin
                        bad++; $display("FAIL db_data f=%0d i=%0d got=%h exp=%h", f, i, bus.rd_data, m_rdata);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        bus.wr_en = 1'b0; bus.wr_sof = 1'b0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_sof = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        test_reset();
        test_write_frame();
        test_read_frame();
        test_overflow();
        test_mid_sof();
        test_reset_mid_read();
        test_random();
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
